// File: rtl/dsp_out_pkg.sv
// rtl/dsp_out_pkg.sv - widths, saturation limits and FIFO entry type shared by dsp_out_stage
package dsp_out_pkg;

    localparam int OUT_W = 18;
    localparam int P_W   = 48;

    // Limits are one bit wider than P so the rounded/shifted value compares without wrap
    localparam logic signed [P_W:0] SAT_MAX = 49'sd131071;
    localparam logic signed [P_W:0] SAT_MIN = -49'sd131072;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             sat;
        logic             carry;
    } fifo_entry_t;

endpackage

// File: rtl/dsp_out_fifo.sv
// rtl/dsp_out_fifo.sv - synchronous result FIFO with occupancy output; push at full succeeds only with a same-cycle pop
module dsp_out_fifo
    import dsp_out_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  fifo_entry_t      wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output fifo_entry_t      rd_data,
    output logic             full,
    output logic [LVL_W-1:0] level
);

    fifo_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign rd_valid = (level != '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign do_pop   = rd_valid && rd_ready;
    assign do_push  = wr_valid && (!full || do_pop);
    // Head is masked while empty so the output reads zero out of reset
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dsp_out_stage.sv
// rtl/dsp_out_stage.sv - DSP48A1 output capture, shift/round/saturate and credit-based result FIFO (rounding under DSPOUT_ROUND_EN)
module dsp_out_stage
    import dsp_out_pkg::*;
#(
    parameter int  LATENCY = 4,
    parameter int  DEPTH   = 8,
    parameter int  SHIFT   = 0,
    localparam int LVL_W   = $clog2(DEPTH + 1),
    localparam int INF_W   = $clog2(LATENCY + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ISSUE_VALID,
    output logic             ISSUE_READY,
    input  logic [P_W-1:0]   P,
    input  logic             CARRYOUT,
    output logic [OUT_W-1:0] OUT_DATA,
    output logic             OUT_SAT,
    output logic             OUT_CARRY,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [LVL_W-1:0] LEVEL,
    output logic             OVERFLOW,
    input  logic             CLR_OVF
);

`ifdef DSPOUT_ROUND_EN
    localparam logic [P_W:0] RND_ADD =
        (SHIFT > 0) ? ((P_W + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
    localparam logic [P_W:0] RND_ADD = '0;
`endif

    logic [LATENCY-1:0] vpipe;
    logic [INF_W-1:0]   inflight;
    logic               capture;
    logic               fifo_full;
    logic               drop;
    logic signed [P_W:0] p_rnd;
    logic signed [P_W:0] s_val;
    fifo_entry_t        result;
    fifo_entry_t        head;

    assign capture = vpipe[LATENCY-1];

    always_ff @(posedge CLK) begin
        if (RST) vpipe <= '0;
        else     vpipe <= (vpipe << 1) | LATENCY'(ISSUE_VALID);
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + INF_W'(vpipe[i]);
        end
    end

    // Credits cover both stored and still-in-flight results, so a compliant upstream never causes a drop
    assign ISSUE_READY = (int'(LEVEL) + int'(inflight)) < DEPTH;

    always_comb begin
        p_rnd        = $signed({P[P_W-1], P}) + $signed(RND_ADD);
        s_val        = p_rnd >>> SHIFT;
        result       = '0;
        result.carry = CARRYOUT;
        if (s_val > SAT_MAX) begin
            result.data = SAT_MAX[OUT_W-1:0];
            result.sat  = 1'b1;
        end else if (s_val < SAT_MIN) begin
            result.data = SAT_MIN[OUT_W-1:0];
            result.sat  = 1'b1;
        end else begin
            result.data = s_val[OUT_W-1:0];
        end
    end

    dsp_out_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_valid (capture),
        .wr_data  (result),
        .rd_ready (OUT_READY),
        .rd_valid (OUT_VALID),
        .rd_data  (head),
        .full     (fifo_full),
        .level    (LEVEL)
    );

    assign OUT_DATA  = head.data;
    assign OUT_SAT   = head.sat;
    assign OUT_CARRY = head.carry;

    assign drop = capture && fifo_full && !(OUT_VALID && OUT_READY);

    // A new drop wins over a same-cycle clear
    always_ff @(posedge CLK) begin
        if (RST)          OVERFLOW <= 1'b0;
        else if (drop)    OVERFLOW <= 1'b1;
        else if (CLR_OVF) OVERFLOW <= 1'b0;
    end

endmodule
